simd_result_drain: RTL and testbench
====================================

Name: simd_result_drain

Overview:
- Sits downstream of simd_cell and reads its `product_reg` matrix once per temporal window.
- Snapshots the whole DIM_C x DIM_A product matrix into a shadow buffer when the window completes.
- Serialises the snapshot as a valid/ready stream of one product per beat, carrying c/a indices and a last flag, toward the writeback/accumulation stage.
- Tracks window boundaries itself from the same `enable` that drives the cell.

Parameters:
- DIM_A, `DIM_A: inputs per cell (inner index).
- DIM_C, `DIM_C: weights per cell (outer index).
- ACC_WIDTH, `ACC_WIDTH: width of one product entry.
- INPUT_WIDTH, `INPUT_WIDTH: window length is 2^INPUT_WIDTH enabled cycles.
- CAPTURE_LAT, 2: cycles from the last enabled cycle of a window until `product_reg` holds that window's final value.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- enable  in  1  same enable as simd_cell; advances the window counter
- product_in  in  DIM_C*DIM_A*ACC_WIDTH  simd_cell product_reg, packed [c][a]
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  ACC_WIDTH  product entry
- out_c  out  $clog2(DIM_C) (min 1)  outer index
- out_a  out  $clog2(DIM_A) (min 1)  inner index
- out_last  out  1  final beat of the snapshot
- busy  out  1  snapshot not yet fully drained
- overrun  out  1  sticky: a capture occurred while busy
- clear_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst_n low):
  - win_cnt = 0; capture pipe cleared; state IDLE.
  - out_valid, out_last, busy, overrun = 0; out_data, out_c, out_a = 0.
  - Shadow buffer = 0.
- Window counter:
  - win_cnt is INPUT_WIDTH bits; it increments only when enable = 1.
  - It wraps from 2^INPUT_WIDTH-1 to 0.
  - enable low holds the count; there is no penalty for enable gaps.
- Capture pipe:
  - win_end = enable && win_cnt == all-ones.
  - win_end is shifted through a CAPTURE_LAT-deep shift register.
  - Its output, cap, is the capture strobe.
  - CAPTURE_LAT = 0 means cap = win_end in the same cycle.
- FSM with two states, IDLE and DRAIN:
  - IDLE & cap: copy product_in to the shadow buffer, set idx c = 0, a = 0, go to DRAIN. out_valid rises the next cycle.
  - DRAIN: out_valid = 1, out_data = shadow[c][a], out_last = (c == DIM_C-1 && a == DIM_A-1).
  - A handshake (out_valid && out_ready) advances a first. When a wraps to 0, c increments.
  - A handshake on the last beat returns the FSM to IDLE.
  - out_data, out_c, out_a, out_last stay stable while out_valid && !out_ready.
- busy = (state == DRAIN).
- Collisions:
  - cap in the same cycle as the last-beat handshake: new snapshot is accepted. The FSM stays in DRAIN with idx = 0; this is not an overrun.
  - cap while in DRAIN, not on the last handshake: the snapshot is dropped, the shadow buffer is unchanged, and overrun is set.
  - clear_overrun and a new overrun in the same cycle: overrun ends at 1 (set wins).
- Throughput: one beat per cycle with out_ready held high, so drain takes DIM_C*DIM_A cycles. This is lossless iff DIM_C*DIM_A <= 2^INPUT_WIDTH.
- Reset asserted mid-drain: the snapshot is abandoned and all state returns to reset values immediately.
- No combinational path from out_ready to out_valid.

Optional Feature:
- Macro SIMD_DRAIN_PERF_EN.
- When defined, two extra outputs are added:
  - perf_stall_cnt [15:0]: counts cycles with out_valid && !out_ready; saturates at 0xFFFF.
  - perf_win_cnt [15:0]: counts accepted captures; wraps.
  - Both reset to 0 and are cleared by clear_overrun.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package simd_pkg holds:
  - drain_state_t enum {IDLE, DRAIN}.
  - Typedef prod_mat_t, matching [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0].
  - localparams C_IDX_W, A_IDX_W, and NUM_ENTRIES = DIM_C*DIM_A.
- One sub-module, simd_window_tracker: win_cnt plus the CAPTURE_LAT pipe, producing cap. The FSM, shadow buffer and output muxing stay in simd_result_drain.

Test Plan (DIM_A=2, DIM_C=2, INPUT_WIDTH=3, ACC_WIDTH=8, CAPTURE_LAT=2):
- Basic drain:
  - Stimulus: enable high 8 cycles, product_in = {c1a1=0x44, c1a0=0x33, c0a1=0x22, c0a0=0x11}, out_ready = 1.
  - Response: cap 2 cycles after the 8th enabled cycle. Beats 0x11 (0,0), 0x22 (0,1), 0x33 (1,0), 0x44 (1,1), with out_last only on 0x44. busy falls after beat 4.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles during beat 2.
  - Response: out_data = 0x22 and out_a = 1 held stable for 3 cycles; then the drain completes in order. PERF build: perf_stall_cnt = 3.
- Enable gaps:
  - Stimulus: enable toggles 1,0,1,0 across 16 cycles (8 enabled).
  - Response: exactly one capture, timed from the 8th enabled cycle.
- Overrun:
  - Stimulus: out_ready = 0 through a full second window.
  - Response: second capture dropped, overrun = 1, buffer still streams the window-1 values. clear_overrun pulse drops overrun to 0.
- Collision:
  - Stimulus: align cap with the last-beat handshake.
  - Response: overrun stays 0; the next cycle shows out_valid = 1, out_c = 0, out_a = 0 with the new data.
- Reset mid-drain:
  - Stimulus: rst_n low after beat 2.
  - Response: out_valid = 0, busy = 0, overrun = 0 asynchronously, and the counter restarts at 0.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared types and geometry for the simd_cell result drain path.
// Dimensions come from the DIM_A / DIM_C / ACC_WIDTH / INPUT_WIDTH macros when defined.
`ifndef DIM_A
`define DIM_A 2
`endif
`ifndef DIM_C
`define DIM_C 2
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 8
`endif
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 3
`endif

package simd_pkg;

  localparam int unsigned DIM_A       = `DIM_A;
  localparam int unsigned DIM_C       = `DIM_C;
  localparam int unsigned ACC_WIDTH   = `ACC_WIDTH;
  localparam int unsigned INPUT_WIDTH = `INPUT_WIDTH;

  localparam int unsigned C_IDX_W     = (DIM_C > 1) ? $clog2(DIM_C) : 1;
  localparam int unsigned A_IDX_W     = (DIM_A > 1) ? $clog2(DIM_A) : 1;
  localparam int unsigned NUM_ENTRIES = DIM_C * DIM_A;

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_t;

  typedef logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] prod_mat_t;

endpackage

// File: rtl/simd_window_tracker.sv
// Counts enabled cycles of a temporal window and emits a capture strobe CAPTURE_LAT cycles
// after the last enabled cycle, when the cell's product_reg has settled.
module simd_window_tracker
  import simd_pkg::*;
#(
  parameter int unsigned CAPTURE_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic cap
);

  logic [INPUT_WIDTH-1:0] r_win_cnt;
  logic                   w_win_end;

  assign w_win_end = enable && (r_win_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt <= '0;
    end else if (enable) begin
      r_win_cnt <= r_win_cnt + 1'b1;
    end
  end

  generate
    if (CAPTURE_LAT == 0) begin : g_no_pipe
      assign cap = w_win_end;
    end else begin : g_pipe
      logic [CAPTURE_LAT-1:0] r_pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= w_win_end;
          for (int i = 1; i < CAPTURE_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign cap = r_pipe[CAPTURE_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/simd_result_drain.sv
// Snapshots the simd_cell product matrix at each window end and streams it out one entry per beat.
// Optional SIMD_DRAIN_PERF_EN adds stall and capture counters.
module simd_result_drain
  import simd_pkg::*;
#(
  parameter int unsigned CAPTURE_LAT = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic [DIM_C*DIM_A*ACC_WIDTH-1:0]   product_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ACC_WIDTH-1:0]               out_data,
  output logic [C_IDX_W-1:0]                 out_c,
  output logic [A_IDX_W-1:0]                 out_a,
  output logic                               out_last,
  output logic                               busy,
  output logic                               overrun,
  input  logic                               clear_overrun
`ifdef SIMD_DRAIN_PERF_EN
  ,
  output logic [15:0]                        perf_stall_cnt,
  output logic [15:0]                        perf_win_cnt
`endif
);

  localparam logic [C_IDX_W-1:0] C_LAST = C_IDX_W'(DIM_C - 1);
  localparam logic [A_IDX_W-1:0] A_LAST = A_IDX_W'(DIM_A - 1);

  drain_state_t         r_state, w_state_d;
  prod_mat_t            r_shadow;
  logic [C_IDX_W-1:0]   r_c, w_c_d;
  logic [A_IDX_W-1:0]   r_a, w_a_d;
  logic                 r_overrun;
  logic                 w_cap;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_load;
  logic                 w_ov_set;

  simd_window_tracker #(
    .CAPTURE_LAT (CAPTURE_LAT)
  ) u_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .cap    (w_cap)
  );

  assign w_hs   = (r_state == DRAIN) && out_ready;
  assign w_last = (r_state == DRAIN) && (r_c == C_LAST) && (r_a == A_LAST);

  always_comb begin
    w_state_d = r_state;
    w_c_d     = r_c;
    w_a_d     = r_a;
    w_load    = 1'b0;
    w_ov_set  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cap) begin
          w_load    = 1'b1;
          w_c_d     = '0;
          w_a_d     = '0;
          w_state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (w_hs && w_last) begin
          // A capture landing on the final handshake starts the next drain back-to-back.
          w_c_d = '0;
          w_a_d = '0;
          if (w_cap) begin
            w_load = 1'b1;
          end else begin
            w_state_d = IDLE;
          end
        end else begin
          if (w_hs) begin
            if (r_a == A_LAST) begin
              w_a_d = '0;
              w_c_d = r_c + 1'b1;
            end else begin
              w_a_d = r_a + 1'b1;
            end
          end
          if (w_cap) begin
            w_ov_set = 1'b1;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_c       <= '0;
      r_a       <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_c       <= w_c_d;
      r_a       <= w_a_d;
      r_overrun <= w_ov_set | (r_overrun & ~clear_overrun);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_load) begin
      r_shadow <= product_in;
    end
  end

  // Outputs depend on registered state only, so out_ready never reaches out_valid.
  assign out_valid = (r_state == DRAIN);
  assign busy      = out_valid;
  assign out_data  = out_valid ? r_shadow[r_c][r_a] : '0;
  assign out_c     = r_c;
  assign out_a     = r_a;
  assign out_last  = w_last;
  assign overrun   = r_overrun;

`ifdef SIMD_DRAIN_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_pwin_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_pwin_cnt  <= '0;
    end else if (clear_overrun) begin
      r_stall_cnt <= '0;
      r_pwin_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_load) begin
        r_pwin_cnt <= r_pwin_cnt + 16'd1;
      end
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_win_cnt   = r_pwin_cnt;
`endif

endmodule

// File: tb/tb_simd_result_drain.sv
// Scoreboard bench for simd_result_drain (DIM_A=2, DIM_C=2, INPUT_WIDTH=3, ACC_WIDTH=8).
module tb_simd_result_drain;
  import simd_pkg::*;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] d;
    logic [C_IDX_W-1:0]   c;
    logic [A_IDX_W-1:0]   a;
    logic                 last;
  } beat_t;

  logic                             clk = 1'b0;
  logic                             rst_n = 1'b0;
  logic                             enable = 1'b0;
  logic                             out_ready = 1'b1;
  logic                             clear_overrun = 1'b0;
  logic [DIM_C*DIM_A*ACC_WIDTH-1:0] product_in = '0;
  logic                             out_valid;
  logic [ACC_WIDTH-1:0]             out_data;
  logic [C_IDX_W-1:0]               out_c;
  logic [A_IDX_W-1:0]               out_a;
  logic                             out_last;
  logic                             busy;
  logic                             overrun;
`ifdef SIMD_DRAIN_PERF_EN
  logic [15:0]                      perf_stall_cnt;
  logic [15:0]                      perf_win_cnt;
`endif

  beat_t q_exp[$];
  beat_t q_got[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    got_rd  = 0;

  always #5 clk = ~clk;

  simd_result_drain #(
    .CAPTURE_LAT (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .product_in     (product_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_c          (out_c),
    .out_a          (out_a),
    .out_last       (out_last),
    .busy           (busy),
    .overrun        (overrun),
    .clear_overrun  (clear_overrun)
`ifdef SIMD_DRAIN_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_win_cnt   (perf_win_cnt)
`endif
  );

  // Record every accepted beat; handshake completes at the following posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_got.push_back({out_data, out_c, out_a, out_last});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_window(input prod_mat_t m, input int n);
    int k;
    k = 0;
    for (int c = 0; c < int'(DIM_C); c++) begin
      for (int a = 0; a < int'(DIM_A); a++) begin
        if (k < n) begin
          q_exp.push_back({m[c][a], C_IDX_W'(c), A_IDX_W'(a),
                           (c == int'(DIM_C) - 1) && (a == int'(DIM_A) - 1)});
        end
        k++;
      end
    end
  endtask

  task automatic run_window();
    enable = 1'b1;
    repeat (2 ** INPUT_WIDTH) tick();
    enable = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got valid=%b busy=%b ovr=%b last=%b, required all 0",
               out_valid, busy, overrun, out_last);
    end
    n_tests++;
    if (out_data !== '0 || out_c !== '0 || out_a !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got d=%h c=%0d a=%0d, required 0", out_data, out_c, out_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    beat_t e, g;
    product_in = {8'h44, 8'h33, 8'h22, 8'h11};
    push_window(product_in, NUM_ENTRIES);
    run_window();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_early1: got busy=%b, required 0", busy);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_early2: got busy=%b, required 0", busy);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_first: got valid=%b d=%h last=%b, required 1 11 0",
               out_valid, out_data, out_last);
    end
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b1 || out_last !== 1'b1 || out_data !== 8'h44) begin
      n_fail++;
      $display("FAIL basic_lastbeat: got busy=%b last=%b d=%h, required 1 1 44",
               busy, out_last, out_data);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_fall: got busy=%b, required 0", busy);
    end
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front();
      n_tests++;
      if (got_rd >= q_got.size()) begin
        n_fail++; $display("FAIL basic_beat: got none, required d=%h", e.d);
      end else begin
        g = q_got[got_rd]; got_rd++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL basic_beat: got d=%h c=%0d a=%0d l=%b, required d=%h c=%0d a=%0d l=%b",
                   g.d, g.c, g.a, g.last, e.d, e.c, e.a, e.last);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t e, g;
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    product_in = {8'h44, 8'h33, 8'h22, 8'h11};
    push_window(product_in, NUM_ENTRIES);
    run_window();
    repeat (2) tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h22 || out_a !== 1'b1 || out_c !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b d=%h c=%0d a=%0d, required 1 22 0 1",
                 i, out_valid, out_data, out_c, out_a);
      end
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
`ifdef SIMD_DRAIN_PERF_EN
    n_tests++;
    if (perf_stall_cnt !== 16'd3 || perf_win_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_perf: got stall=%0d win=%0d, required 3 1", perf_stall_cnt, perf_win_cnt);
    end
`endif
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front();
      n_tests++;
      if (got_rd >= q_got.size()) begin
        n_fail++; $display("FAIL bp_beat: got none, required d=%h", e.d);
      end else begin
        g = q_got[got_rd]; got_rd++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL bp_beat: got d=%h c=%0d a=%0d, required d=%h c=%0d a=%0d",
                   g.d, g.c, g.a, e.d, e.c, e.a);
        end
      end
    end
  endtask

  task automatic test_enable_gaps();
    beat_t e, g;
    logic  early;
    early = 1'b0;
    product_in = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
    push_window(product_in, NUM_ENTRIES);
    for (int i = 0; i < 16; i++) begin
      enable = (i % 2 == 0);
      tick();
      if (busy) early = 1'b1;
    end
    enable = 1'b0;
    n_tests++;
    if (early !== 1'b0) begin
      n_fail++; $display("FAIL gaps_early: got early capture=%b, required 0", early);
    end
    tick();
    n_tests++;
    if (busy !== 1'b1 || out_data !== 8'hA1) begin
      n_fail++; $display("FAIL gaps_cap: got busy=%b d=%h, required 1 a1", busy, out_data);
    end
    wait_idle();
    repeat (12) tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL gaps_single: got busy=%b, required 0", busy);
    end
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front();
      n_tests++;
      if (got_rd >= q_got.size()) begin
        n_fail++; $display("FAIL gaps_beat: got none, required d=%h", e.d);
      end else begin
        g = q_got[got_rd]; got_rd++;
        if (g !== e) begin
          n_fail++; $display("FAIL gaps_beat: got d=%h, required d=%h", g.d, e.d);
        end
      end
    end
  endtask

  task automatic test_overrun();
    beat_t e, g;
    out_ready = 1'b0;
    product_in = {8'hB4, 8'hB3, 8'hB2, 8'hB1};
    push_window(product_in, NUM_ENTRIES);
    run_window();
    repeat (2) tick();
    product_in = {8'hC4, 8'hC3, 8'hC2, 8'hC1};
    run_window();
    tick();
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL ovr_early: got overrun=%b, required 0", overrun);
    end
    tick();
    n_tests++;
    if (overrun !== 1'b1 || busy !== 1'b1 || out_data !== 8'hB1) begin
      n_fail++;
      $display("FAIL ovr_set: got overrun=%b busy=%b d=%h, required 1 1 b1", overrun, busy, out_data);
    end
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear: got overrun=%b, required 0", overrun);
    end
    out_ready = 1'b1;
    wait_idle();
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front();
      n_tests++;
      if (got_rd >= q_got.size()) begin
        n_fail++; $display("FAIL ovr_beat: got none, required d=%h", e.d);
      end else begin
        g = q_got[got_rd]; got_rd++;
        if (g !== e) begin
          n_fail++; $display("FAIL ovr_beat: got d=%h, required d=%h", g.d, e.d);
        end
      end
    end
  endtask

  task automatic test_collision();
    beat_t     e, g;
    prod_mat_t w1, w2;
    w1 = {8'hD4, 8'hD3, 8'hD2, 8'hD1};
    w2 = {8'hE4, 8'hE3, 8'hE2, 8'hE1};
    push_window(w1, NUM_ENTRIES);
    push_window(w2, NUM_ENTRIES);
    // Window 2 capture lands on cycle 18; stalls 11..14 push the last handshake there too.
    for (int i = 1; i <= 18; i++) begin
      enable     = (i <= 16);
      out_ready  = !(i >= 11 && i <= 14);
      product_in = (i <= 10) ? w1 : w2;
      tick();
    end
    enable    = 1'b0;
    out_ready = 1'b1;
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL coll_ovr: got overrun=%b, required 0", overrun);
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_c !== '0 || out_a !== '0 || out_data !== 8'hE1) begin
      n_fail++;
      $display("FAIL coll_restart: got valid=%b c=%0d a=%0d d=%h, required 1 0 0 e1",
               out_valid, out_c, out_a, out_data);
    end
    wait_idle();
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front();
      n_tests++;
      if (got_rd >= q_got.size()) begin
        n_fail++; $display("FAIL coll_beat: got none, required d=%h", e.d);
      end else begin
        g = q_got[got_rd]; got_rd++;
        if (g !== e) begin
          n_fail++; $display("FAIL coll_beat: got d=%h c=%0d a=%0d, required d=%h c=%0d a=%0d",
                             g.d, g.c, g.a, e.d, e.c, e.a);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    beat_t e, g;
    product_in = {8'hF4, 8'hF3, 8'hF2, 8'hF1};
    push_window(product_in, 2);
    enable = 1'b1;
    repeat (10) tick();  // two extra enabled cycles leave the window counter at 2
    enable = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got valid=%b busy=%b ovr=%b d=%h, required 0 0 0 0",
               out_valid, busy, overrun, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    product_in = {8'h94, 8'h93, 8'h92, 8'h91};
    push_window(product_in, NUM_ENTRIES);
    run_window();
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_cnt_early: got busy=%b, required 0", busy);
    end
    tick();
    n_tests++;
    if (busy !== 1'b1 || out_data !== 8'h91) begin
      n_fail++; $display("FAIL rst_cnt_cap: got busy=%b d=%h, required 1 91", busy, out_data);
    end
    wait_idle();
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front();
      n_tests++;
      if (got_rd >= q_got.size()) begin
        n_fail++; $display("FAIL rst_beat: got none, required d=%h", e.d);
      end else begin
        g = q_got[got_rd]; got_rd++;
        if (g !== e) begin
          n_fail++; $display("FAIL rst_beat: got d=%h, required d=%h", g.d, e.d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_gaps();
    test_overrun();
    test_collision();
    test_reset_mid_drain();
    n_tests++;
    if (q_got.size() != got_rd) begin
      n_fail++;
      $display("FAIL extra_beats: got %0d beats, required %0d", q_got.size(), got_rd);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
